// File: rtl/crt_pix_serializer.sv
// Grayscale CRT pixel serializer: buffers packed video words in a small FIFO and
// unloads PIX_W-bit pixels LSB first on each pixel-clock enable, with blanking and line flush.
module crt_pix_serializer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PIX_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned LW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pxclk,
  input  logic [DATA_W-1:0] video_data_in,
  input  logic              video_data_valid,
  output logic              video_data_ready,
  input  logic              black,
  input  logic              flush,
  input  logic              underflow_clr,
  output logic [PIX_W-1:0]  pixel_data_out,
  output logic [LW-1:0]     fifo_level,
  output logic              underflow
);

  localparam int unsigned PPW = DATA_W / PIX_W;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = (PPW > 1) ? $clog2(PPW) : 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] shift_q;
  logic [CW-1:0]     cnt_q;

  logic          step_c;
  logic          push_c;
  logic          pop_c;
  logic          starve_c;
  logic [LW-1:0] level_nxt_c;
  logic [DATA_W-1:0] head_c;

  // A pixel step that is neither flushed nor blanked either shifts, pops or starves.
  always_comb begin
    step_c      = pxclk && !flush && !black;
    push_c      = video_data_valid && video_data_ready && !flush;
    pop_c       = step_c && (cnt_q == '0) && (fifo_level != '0);
    starve_c    = step_c && (cnt_q == '0) && (fifo_level == '0);
    head_c      = mem[rd_ptr];
    level_nxt_c = fifo_level;
    if (flush) begin
      level_nxt_c = '0;
    end else if (push_c && !pop_c) begin
      level_nxt_c = fifo_level + 1'b1;
    end else if (pop_c && !push_c) begin
      level_nxt_c = fifo_level - 1'b1;
    end
  end

  // Word storage; contents are don't-care until written, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_c && !reset) begin
      mem[wr_ptr] <= video_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      shift_q          <= '0;
      cnt_q            <= '0;
      pixel_data_out   <= '0;
      fifo_level       <= '0;
      video_data_ready <= 1'b1;
      underflow        <= 1'b0;
    end else begin
      fifo_level       <= level_nxt_c;
      video_data_ready <= (level_nxt_c != LW'(FIFO_DEPTH));

      if (flush) begin
        wr_ptr         <= '0;
        rd_ptr         <= '0;
        shift_q        <= '0;
        cnt_q          <= '0;
        pixel_data_out <= '0;
      end else begin
        if (push_c) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pxclk) begin
          if (black) begin
            pixel_data_out <= '0;
            cnt_q          <= '0;
          end else if (cnt_q != '0) begin
            pixel_data_out <= shift_q[PIX_W-1:0];
            shift_q        <= shift_q >> PIX_W;
            cnt_q          <= cnt_q - 1'b1;
          end else if (pop_c) begin
            rd_ptr         <= rd_ptr + 1'b1;
            pixel_data_out <= head_c[PIX_W-1:0];
            shift_q        <= head_c >> PIX_W;
            cnt_q          <= CW'(PPW - 1);
          end else begin
            pixel_data_out <= '0;
          end
        end
      end

      // Setting on starvation takes precedence over a same-cycle clear.
      if (starve_c) begin
        underflow <= 1'b1;
      end else if (underflow_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crt_pix_serializer.sv
// Bench for crt_pix_serializer: two instances (4-bit and 2-bit pixels) share stimulus
// and are compared each cycle against a word/pixel-index model, plus literal spot checks.
module tb_crt_pix_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pxclk;
  logic [7:0] vdata;
  logic       valid;
  logic       black;
  logic       flush;
  logic       uclr;

  logic       rdy0, rdy1;
  logic [3:0] pix0;
  logic [1:0] pix1;
  logic [2:0] lvl0, lvl1;
  logic       uf0, uf1;

  always #5 clk = ~clk;

  crt_pix_serializer #(.DATA_W(8), .PIX_W(4), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .reset(reset), .pxclk(pxclk), .video_data_in(vdata),
    .video_data_valid(valid), .video_data_ready(rdy0), .black(black),
    .flush(flush), .underflow_clr(uclr), .pixel_data_out(pix0),
    .fifo_level(lvl0), .underflow(uf0)
  );

  crt_pix_serializer #(.DATA_W(8), .PIX_W(2), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .reset(reset), .pxclk(pxclk), .video_data_in(vdata),
    .video_data_valid(valid), .video_data_ready(rdy1), .black(black),
    .flush(flush), .underflow_clr(uclr), .pixel_data_out(pix1),
    .fifo_level(lvl1), .underflow(uf1)
  );

  // ---------------- behavioural model ----------------
  logic [7:0] mf    [2][4];
  int         mcnt  [2];
  logic [7:0] pword [2];
  int         pidx  [2];
  int         pend  [2];
  int         mout  [2];
  logic       muf   [2];
  logic       mrdy  [2];

  always @(posedge clk) begin
    logic acc;
    logic uf_set;
    int   pw;
    int   ppw;
    int   mask;
    for (int k = 0; k < 2; k++) begin
      pw   = (k == 0) ? 4 : 2;
      ppw  = 8 / pw;
      mask = (1 << pw) - 1;
      if (reset) begin
        mcnt[k] = 0; pend[k] = 0; pidx[k] = 0; mout[k] = 0;
        muf[k] = 1'b0; mrdy[k] = 1'b1;
      end else begin
        acc    = valid && mrdy[k] && !flush;
        uf_set = 1'b0;
        if (flush) begin
          mcnt[k] = 0; pend[k] = 0; mout[k] = 0;
        end else if (pxclk) begin
          if (black) begin
            mout[k] = 0; pend[k] = 0;
          end else if (pend[k] > 0) begin
            mout[k] = (int'(pword[k]) >> (pidx[k] * pw)) & mask;
            pidx[k]++;
            pend[k]--;
          end else if (mcnt[k] > 0) begin
            pword[k] = mf[k][0];
            for (int j = 0; j < 3; j++) mf[k][j] = mf[k][j+1];
            mcnt[k]--;
            mout[k] = int'(pword[k]) & mask;
            pidx[k] = 1;
            pend[k] = ppw - 1;
          end else begin
            mout[k] = 0;
            muf[k]  = 1'b1;
            uf_set  = 1'b1;
          end
        end
        if (!uf_set && uclr) muf[k] = 1'b0;
        if (acc) begin
          mf[k][mcnt[k]] = vdata;
          mcnt[k]++;
        end
        mrdy[k] = (mcnt[k] != 4);
      end
    end
  end

  // ---------------- literal expectations queue ----------------
  string lit_name [128];
  int    lit_kind [128];
  int    lit_exp  [128];
  int    lit_wr = 0;
  int    lit_rd = 0;
  logic  chk_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic cmp(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  function automatic int act(input int kind);
    case (kind)
      0: return int'(pix0);
      1: return int'(pix1);
      2: return int'(lvl0);
      3: return int'(rdy0);
      4: return int'(uf0);
      5: return int'(uf1);
      6: return int'(lvl1);
      default: return -1;
    endcase
  endfunction

  // Single compare process: model vs both instances, then pending literal checks.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("pix0",  int'(pix0), mout[0]);
      cmp("lvl0",  int'(lvl0), mcnt[0]);
      cmp("rdy0",  int'(rdy0), int'(mrdy[0]));
      cmp("uf0",   int'(uf0),  int'(muf[0]));
      cmp("pix1",  int'(pix1), mout[1]);
      cmp("lvl1",  int'(lvl1), mcnt[1]);
      cmp("rdy1",  int'(rdy1), int'(mrdy[1]));
      cmp("uf1",   int'(uf1),  int'(muf[1]));
    end
    while (lit_rd < lit_wr) begin
      cmp(lit_name[lit_rd], act(lit_kind[lit_rd]), lit_exp[lit_rd]);
      lit_rd++;
    end
  end

  task automatic lit(input string nm, input int kind, input int exp);
    lit_name[lit_wr] = nm;
    lit_kind[lit_wr] = kind;
    lit_exp[lit_wr]  = exp;
    lit_wr++;
  endtask

  task automatic step(input logic px, input logic v, input logic [7:0] d,
                      input logic blk, input logic fl, input logic clr,
                      input logic rst);
    pxclk = px; valid = v; vdata = d; black = blk; flush = fl; uclr = clr; reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic px();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    pxclk = 0; valid = 0; vdata = 0; black = 0; flush = 0; uclr = 0; reset = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    lit("rst_pix0", 0, 0); lit("rst_lvl0", 2, 0); lit("rst_rdy0", 3, 1); lit("rst_uf0", 4, 0);

    // Two words drained on every second clk, then starvation.
    push(8'hA5); push(8'h3C);
    px(); lit("t1_p0", 0, 5); idle();
    px(); lit("t1_p1", 0, 'hA); idle();
    px(); lit("t1_p2", 0, 'hC); idle();
    px(); lit("t1_p3", 0, 3); lit("t1_uf_before", 4, 0); idle();
    px(); lit("t1_p4", 0, 0); lit("t1_uf", 4, 1);

    do_reset();
    lit("rst2_pix0", 0, 0); lit("rst2_lvl0", 2, 0); lit("rst2_uf0", 4, 0); lit("rst2_rdy0", 3, 1);

    // Fill past depth: fifth word waits for the first pop.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    lit("t2_full_lvl", 2, 4); lit("t2_full_rdy", 3, 0);
    push(8'h55); lit("t2_held_lvl", 2, 4);
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("t2_pop_lvl", 2, 3); lit("t2_pop_rdy", 3, 1); lit("t2_pop_pix", 0, 1);
    push(8'h55); lit("t2_acc_lvl", 2, 4);
    repeat (20) px();
    do_reset();

    // Blanking discards the remainder of a word.
    push(8'h21);
    px(); lit("t3_p0", 0, 1);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0); lit("t3_black", 0, 0);
    px(); lit("t3_after", 0, 0); lit("t3_uf0", 4, 1); lit("t3_uf1", 5, 1);

    // Flush with a simultaneous write; underflow survives.
    push(8'h76); push(8'h98); push(8'hBA); lit("t4_lvl3", 2, 3);
    step(1'b1, 1'b1, 8'hDC, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("t4_pp_lvl", 2, 3); lit("t4_pp_pix", 0, 6);
    step(1'b0, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0);
    lit("t4_fl_lvl", 2, 0); lit("t4_fl_pix", 0, 0); lit("t4_fl_uf", 4, 1);
    idle(); lit("t4_drop_lvl", 2, 0);

    // Clear loses against a same-cycle set, works on an idle cycle.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); lit("t5_setwins", 4, 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); lit("t5_clr", 4, 0);

    // 2-bit pixels, then reset in the middle of a word.
    do_reset();
    push(8'hE4);
    px(); lit("t6_p0", 1, 0);
    px(); lit("t6_p1", 1, 1);
    px(); lit("t6_p2", 1, 2);
    px(); lit("t6_p3", 1, 3);
    push(8'hE4);
    px(); lit("t6_m0", 1, 0);
    px(); lit("t6_m1", 1, 1);
    do_reset(); lit("t6_rst_pix", 1, 0); lit("t6_rst_lvl", 6, 0); lit("t6_rst_uf", 5, 0);
    px(); lit("t6_uf", 5, 1); lit("t6_uf_pix", 1, 0); lit("t6_uf_lvl", 6, 0);

    // Randomised traffic checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0),
           8'($urandom),
           1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 199) == 0));
    end

    idle();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
